// File: rtl/coef_rd_pkg.sv
// coef_rd_pkg: shared FSM states, command width and burst sizing helper for the coefficient read engine
package coef_rd_pkg;

    typedef enum logic [1:0] {IDLE, CMD, DATA, DRAIN} state_t;

    localparam int CMD_LEN_W = 8;

    function automatic logic [31:0] min_len(input logic [31:0] remain, input logic [31:0] burst_len);
        return (remain < burst_len) ? remain : burst_len;
    endfunction

endpackage

// File: rtl/coef_rd_fifo.sv
// coef_rd_fifo: prefetch FIFO with registered read data, synchronous flush and word count
module coef_rd_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 256
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [DW-1:0]              i_wdata,
    input  logic                       i_pop,
    input  logic                       i_clr,
    output logic [DW-1:0]              o_rdata,
    output logic [$clog2(DEPTH):0]     o_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;

    // Storage array, written without reset so it maps onto RAM
    always_ff @(posedge i_clk) begin
        if (i_push) mem[wptr] <= i_wdata;
    end

    // Pointers, count and read register; i_clr forces the read word to zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            o_cnt   <= '0;
            o_rdata <= '0;
        end else begin
            if (i_flush) begin
                wptr  <= '0;
                rptr  <= '0;
                o_cnt <= '0;
            end else begin
                if (i_push) wptr <= wptr + 1'b1;
                if (i_pop) rptr <= rptr + 1'b1;
                o_cnt <= o_cnt + CW'(i_push) - CW'(i_pop);
            end
            o_rdata <= i_clr ? '0 : (i_pop ? mem[rptr] : o_rdata);
        end
    end

endmodule

// File: rtl/coef_rd_engine.sv
// coef_rd_engine: burst prefetch of a linear coefficient block, one word per request with 1-cycle latency
// Optional COEF_RD_STAT_EN adds a saturating underflow counter output.
module coef_rd_engine
    import coef_rd_pkg::*;
#(
    parameter int ADDRS_DW   = 21,
    parameter int DW         = 16,
    parameter int BURST_LEN  = 64,
    parameter int FIFO_DEPTH = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rd_start,
    input  logic [ADDRS_DW-1:0]  i_rd_addrs,
    input  logic [ADDRS_DW-1:0]  i_rd_lengths,
    input  logic                 i_rd_req,
    output logic [DW-1:0]        o_rd_data,
    output logic                 o_mem_cmd_valid,
    input  logic                 i_mem_cmd_ready,
    output logic [ADDRS_DW-1:0]  o_mem_cmd_addr,
    output logic [CMD_LEN_W-1:0] o_mem_cmd_len,
    input  logic                 i_mem_rvalid,
    input  logic [DW-1:0]        i_mem_rdata,
    output logic                 o_busy,
    output logic                 o_underflow
`ifdef COEF_RD_STAT_EN
    ,
    output logic [15:0]          o_underflow_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t               state;
    logic [ADDRS_DW-1:0]  cur_addr, remain;
    logic [CMD_LEN_W-1:0] burst_left;
    logic [CW-1:0]        fifo_cnt;
    logic [31:0]          need;
    logic                 room, fifo_empty, push, pop, clr;

    // Next burst size and whether the FIFO can take it whole; start always wins over a request
    always_comb begin
        need       = min_len(32'(remain), 32'(BURST_LEN));
        room       = (32'(FIFO_DEPTH) - 32'(fifo_cnt)) >= need;
        fifo_empty = fifo_cnt == '0;
        push       = (state == DATA) && i_mem_rvalid && !i_rd_start;
        pop        = i_rd_req && !i_rd_start && !fifo_empty;
        clr        = i_rd_start || (i_rd_req && fifo_empty);
    end

    coef_rd_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_rd_start),
        .i_push  (push),
        .i_wdata (i_mem_rdata),
        .i_pop   (pop),
        .i_clr   (clr),
        .o_rdata (o_rd_data),
        .o_cnt   (fifo_cnt)
    );

    // Fetch FSM: one outstanding burst; a start during a burst drains its remaining words
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            cur_addr        <= '0;
            remain          <= '0;
            burst_left      <= '0;
            o_mem_cmd_valid <= 1'b0;
            o_mem_cmd_addr  <= '0;
            o_mem_cmd_len   <= '0;
            o_busy          <= 1'b0;
        end else begin
            if (i_rd_start) begin
                cur_addr <= i_rd_addrs;
                remain   <= i_rd_lengths;
            end
            case (state)
                IDLE: if (!i_rd_start && remain != '0 && room) begin
                    state           <= CMD;
                    o_busy          <= 1'b1;
                    o_mem_cmd_valid <= 1'b1;
                    o_mem_cmd_addr  <= cur_addr;
                    o_mem_cmd_len   <= need[CMD_LEN_W-1:0];
                end
                CMD: if (i_mem_cmd_ready) begin
                    // The handshake happens on the bus even if start arrives with it, so drain in that case
                    o_mem_cmd_valid <= 1'b0;
                    burst_left      <= o_mem_cmd_len;
                    state           <= i_rd_start ? DRAIN : DATA;
                    if (!i_rd_start) begin
                        cur_addr <= cur_addr + ADDRS_DW'(o_mem_cmd_len);
                        remain   <= remain - ADDRS_DW'(o_mem_cmd_len);
                    end
                end else if (i_rd_start) begin
                    o_mem_cmd_valid <= 1'b0;
                    o_busy          <= 1'b0;
                    state           <= IDLE;
                end
                DATA, DRAIN: begin
                    if (i_mem_rvalid) burst_left <= burst_left - 1'b1;
                    if (i_mem_rvalid && burst_left == CMD_LEN_W'(1)) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else if (i_rd_start) begin
                        state <= DRAIN;
                    end
                end
            endcase
        end
    end

    // Sticky underflow flag: set by a request on an empty FIFO, cleared by start
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_underflow <= 1'b0;
        else if (i_rd_start) o_underflow <= 1'b0;
        else if (i_rd_req && fifo_empty) o_underflow <= 1'b1;
    end

`ifdef COEF_RD_STAT_EN
    // Saturating count of underflowing requests, cleared by start
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_underflow_cnt <= '0;
        else if (i_rd_start) o_underflow_cnt <= '0;
        else if (i_rd_req && fifo_empty && o_underflow_cnt != 16'hFFFF) o_underflow_cnt <= o_underflow_cnt + 1'b1;
    end
`endif

endmodule
